// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared types and defaults for the UART data-path FIFO.
//   fifo_op_e        - decoded accepted operation {push, pop}
//   FifoWidthDefault - default data word width shared with the UART top
//   FifoDepthDefault - default entry count shared with the UART top
package uart_fifo_pkg;

  localparam int unsigned FifoWidthDefault = 8;
  localparam int unsigned FifoDepthDefault = 16;

  // Encoding is {push_acc, pop_acc} so the decode is a direct cast.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port storage array, synchronous write, asynchronous read.
// Kept separate so synthesis can map it to distributed RAM.
//   clk_i    - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
module uart_fifo_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_param.sv
// uart_fifo_param: parametrised circular-buffer FIFO for the UART TX/RX data paths.
// Optional receive character timeout is built when UART_FIFO_TIMEOUT_EN is defined.
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   en           - enable; low flushes pointers, count and error flags on the next edge
//   push_in      - write request, din written when accepted
//   pop_in       - read request
//   dout         - head entry, first-word fall-through
//   threshold    - compare value for thre_trigger
//   level        - entry count 0..DEPTH
//   empty/full   - level == 0 / level == DEPTH
//   overrun      - one-cycle pulse after a rejected push
//   underrun     - one-cycle pulse after a rejected pop
//   thre_trigger - registered level >= threshold
//   timeout      - character-timeout flag (0 when the timeout build is off)
module uart_fifo_param
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH          = FifoWidthDefault,
  parameter int unsigned DEPTH          = FifoDepthDefault,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [CW-1:0]    threshold,
  output logic [CW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  output logic             underrun,
  output logic             thre_trigger,
  output logic             timeout
);

  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, underrun_q, thre_q;
  logic          push_acc, pop_acc;
  fifo_op_e      op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign pop_acc  = pop_in & en & ~empty;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign push_acc = push_in & en & (~full | pop_acc);
  assign op       = fifo_op_e'({push_acc, pop_acc});

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (!en) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      unique case (op)
        IDLE: ;
        PUSH: begin
          wptr_d  = wptr_q + AW'(1);
          count_d = count_q + CW'(1);
        end
        POP: begin
          rptr_d  = rptr_q + AW'(1);
          count_d = count_q - CW'(1);
        end
        BOTH: begin
          wptr_d = wptr_q + AW'(1);
          rptr_d = rptr_q + AW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      thre_q     <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overrun_q  <= push_in & en & full & ~pop_acc;
      underrun_q <= pop_in & en & empty;
      thre_q     <= (count_d >= threshold);
    end
  end

  assign level        = count_q;
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;
  assign thre_trigger = thre_q;

  uart_fifo_ram #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push_acc),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .raddr_i (rptr_q),
    .rdata_o (dout)
  );

`ifdef UART_FIFO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IdleMax = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q;

  // Counts idle cycles with data held; saturates so the flag stays up.
  always_comb begin
    idle_d = idle_q;
    if (!en || empty || (op != IDLE)) begin
      idle_d = '0;
    end else if (idle_q != IdleMax) begin
      idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= (idle_d == IdleMax);
    end
  end

  assign timeout = timeout_q;
`else
  // TIMEOUT_CYCLES only matters in the timeout build; the term is always 0.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_uart_fifo_param.sv
module tb_uart_fifo_param;

`ifdef UART_FIFO_TIMEOUT_EN
  localparam logic ToExp = 1'b1;
`else
  localparam logic ToExp = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, push_in, pop_in;
  logic [7:0] din, dout;
  logic [4:0] threshold, level;
  logic       empty, full, overrun, underrun, thre_trigger, timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_fifo_param #(
    .WIDTH          (8),
    .DEPTH          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .push_in      (push_in),
    .pop_in       (pop_in),
    .din          (din),
    .dout         (dout),
    .threshold    (threshold),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .underrun     (underrun),
    .thre_trigger (thre_trigger),
    .timeout      (timeout)
  );

  typedef struct {
    logic       rst, en, push, pop;
    logic [7:0] din;
    logic [4:0] thr;
    int         lvl;
    logic       ovr, und, thre;
    logic       chk_dout;
    logic [7:0] dout;
    logic       chk_to;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic pu, input logic po,
                              input logic [7:0] d, input logic [4:0] t, input int l,
                              input logic ov, input logic un, input logic th,
                              input logic cd, input logic [7:0] dv,
                              input logic ct = 1'b0, input logic tv = 1'b0);
    vec_t v;
    v.rst = r; v.en = e; v.push = pu; v.pop = po; v.din = d; v.thr = t; v.lvl = l;
    v.ovr = ov; v.und = un; v.thre = th; v.chk_dout = cd; v.dout = dv;
    v.chk_to = ct; v.to = tv;
    vecs.push_back(v);
  endfunction

  task automatic chk(input int idx, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL vec %0d %s: got %0h want %0h", idx, what, act, exp);
      miscompares++;
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    rst = v.rst; en = v.en; push_in = v.push; pop_in = v.pop;
    din = v.din; threshold = v.thr;
    @(posedge clk);
    #1;
    vectors++;
    chk(idx, "level", 32'(level), 32'(v.lvl));
    chk(idx, "empty", 32'(empty), 32'(v.lvl == 0));
    chk(idx, "full", 32'(full), 32'(v.lvl == 16));
    chk(idx, "overrun", 32'(overrun), 32'(v.ovr));
    chk(idx, "underrun", 32'(underrun), 32'(v.und));
    chk(idx, "thre_trigger", 32'(thre_trigger), 32'(v.thre));
    if (v.chk_dout) chk(idx, "dout", 32'(dout), 32'(v.dout));
    if (v.chk_to) chk(idx, "timeout", 32'(timeout), 32'(v.to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    rst = 1'b1; en = 1'b1; push_in = 1'b0; pop_in = 1'b0; din = '0; threshold = 5'd17;
    #1;

    // Reset with requests pending: reset must win and hold everything cleared.
    rv = '{rst: 1, en: 1, push: 1, pop: 0, din: 8'hC3, thr: 5'd0, lvl: 0, ovr: 0, und: 0,
           thre: 0, chk_dout: 0, dout: 8'h00, chk_to: 1, to: 0};
    apply(-2, rv);
    rv.pop = 1'b1;
    apply(-1, rv);

    // Fill to full, overrun, drain.
    for (int i = 1; i <= 16; i++) add(0, 1, 1, 0, 8'(i), 5'd16, i, 0, 0, (i >= 16), 1, 8'h01);
    add(0, 1, 1, 0, 8'hAA, 5'd16, 16, 1, 0, 1, 1, 8'h01);
    add(0, 1, 0, 0, 8'h00, 5'd16, 16, 0, 0, 1, 1, 8'h01);
    for (int k = 1; k <= 16; k++) add(0, 1, 0, 1, 8'h00, 5'd16, 16 - k, 0, 0, 0, (k < 16),
                                      8'(k + 1));

    // Wrap-around.
    for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 8'(8'h30 + i), 5'd17, i + 1, 0, 0, 0, 1, 8'h30);
    for (int k = 1; k <= 10; k++) add(0, 1, 0, 1, 8'h00, 5'd17, 10 - k, 0, 0, 0, (k < 10),
                                      8'(8'h30 + k));
    for (int i = 0; i < 12; i++) add(0, 1, 1, 0, 8'(8'h20 + i), 5'd17, i + 1, 0, 0, 0, 1, 8'h20);
    for (int k = 1; k <= 12; k++) add(0, 1, 0, 1, 8'h00, 5'd17, 12 - k, 0, 0, 0, (k < 12),
                                      8'(8'h20 + k));

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) add(0, 1, 1, 0, 8'(8'h40 + i), 5'd17, i + 1, 0, 0, 0, 1, 8'h40);
    add(0, 1, 1, 1, 8'h55, 5'd17, 16, 0, 0, 0, 1, 8'h41);
    for (int k = 1; k <= 15; k++) add(0, 1, 0, 1, 8'h00, 5'd17, 16 - k, 0, 0, 0, 1,
                                      (k < 15) ? 8'(8'h41 + k) : 8'h55);
    add(0, 1, 0, 1, 8'h00, 5'd17, 0, 0, 0, 0, 0, 8'h00);

    // Push and pop together while empty.
    add(0, 1, 1, 1, 8'h77, 5'd17, 1, 0, 1, 0, 1, 8'h77);
    add(0, 1, 0, 0, 8'h00, 5'd17, 1, 0, 0, 0, 1, 8'h77);
    add(0, 1, 0, 1, 8'h00, 5'd17, 0, 0, 0, 0, 0, 8'h00);

    // Threshold and flush.
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 8'(8'h60 + i), 5'd4, i + 1, 0, 0, (i == 3), 1,
                                    8'h60);
    add(0, 1, 0, 1, 8'h00, 5'd4, 3, 0, 0, 0, 1, 8'h61);
    add(0, 0, 1, 1, 8'hEE, 5'd4, 0, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 5'd4, 0, 0, 0, 0, 0, 8'h00);
    add(0, 1, 0, 0, 8'h00, 5'd4, 0, 0, 0, 0, 0, 8'h00);

    // Reset mid-operation, then threshold zero.
    add(0, 1, 1, 0, 8'h90, 5'd17, 1, 0, 0, 0, 1, 8'h90);
    add(0, 1, 1, 0, 8'h91, 5'd17, 2, 0, 0, 0, 1, 8'h90);
    add(1, 1, 1, 0, 8'h92, 5'd17, 0, 0, 0, 0, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h00, 5'd17, 0, 0, 0, 0, 0, 8'h00);
    add(0, 1, 0, 0, 8'h00, 5'd0, 0, 0, 0, 1, 0, 8'h00);

    // Character timeout: one entry held, then idle.
    add(0, 1, 1, 0, 8'h11, 5'd17, 1, 0, 0, 0, 1, 8'h11, 1, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 0, 8'h00, 5'd17, 1, 0, 0, 0, 1, 8'h11, 1, 0);
    add(0, 1, 0, 0, 8'h00, 5'd17, 1, 0, 0, 0, 1, 8'h11, 1, ToExp);
    add(0, 1, 0, 0, 8'h00, 5'd17, 1, 0, 0, 0, 1, 8'h11, 1, ToExp);
    add(0, 1, 0, 1, 8'h00, 5'd17, 0, 0, 0, 0, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h00, 5'd17, 0, 0, 0, 0, 0, 8'h00, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
